// File: rtl/io_port_bank.sv
// io_port_bank: addressable bank of output latches and debounced inputs.
// Addresses 0..OUTPUT_SIZE-1 select output latches; the next INPUT_SIZE
// addresses select debounced input pins; anything above reads as 0 and
// raises addr_err for one cycle.
module io_port_bank #(
    parameter int                     ADDR_WIDTH      = 4,
    parameter int                     OUTPUT_SIZE     = 8,
    parameter int                     INPUT_SIZE      = 7,
    parameter int                     SYNC_STAGES     = 2,
    parameter int                     DEBOUNCE_CYCLES = 3,
    parameter logic [OUTPUT_SIZE-1:0] OUTPUT_RESET    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic                  data_in,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic                  data_out,
    output logic                  addr_err,
    input  logic [INPUT_SIZE-1:0] input_pins,
    output logic [OUTPUT_SIZE-1:0] output_pins
);

    localparam int MAPPED = OUTPUT_SIZE + INPUT_SIZE;
    localparam int MAP_W  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] MAPPED_LIM = (ADDR_WIDTH + 1)'(MAPPED);

    // Configuration sanity: the address space must hold every mapped bit.
    if (MAPPED > MAP_W) begin : g_bad_map
        $error("io_port_bank: OUTPUT_SIZE+INPUT_SIZE exceeds 2**ADDR_WIDTH");
    end
    if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("io_port_bank: SYNC_STAGES must be 1..4");
    end
    if (DEBOUNCE_CYCLES < 0 || DEBOUNCE_CYCLES > 255) begin : g_bad_deb
        $error("io_port_bank: DEBOUNCE_CYCLES must be 0..255");
    end

    logic [OUTPUT_SIZE-1:0] latch_q, latch_d;
    logic                   addr_err_q, addr_err_d;
    logic [INPUT_SIZE-1:0]  sync_q [SYNC_STAGES];
    logic [INPUT_SIZE-1:0]  sync;
    logic [INPUT_SIZE-1:0]  stable_q, stable_d;
    logic [MAP_W-1:0]       rd_map;

    // Decode a write into the single addressed output latch; other addresses leave latches alone.
    always_comb begin
        latch_d = latch_q;
        if (write) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
                if (address == ADDR_WIDTH'(i)) begin
                    latch_d[i] = data_in;
                end
            end
        end
    end

    // Output latches; reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_q <= OUTPUT_RESET;
        end else begin
            latch_q <= latch_d;
        end
    end

    // Flag any cycle that presented an address beyond the mapped range.
    always_comb begin
        addr_err_d = ({1'b0, address} >= MAPPED_LIM);
    end

    // Registered address-error flag, visible the cycle after the bad access.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    // Synchroniser chain for the asynchronous input pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= input_pins;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        // No filtering: the stable copy simply follows the synchroniser.
        always_comb begin
            stable_d = sync;
        end
    end else begin : g_debounce
        localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

        logic [CNT_W-1:0] cnt_q [INPUT_SIZE];
        logic [CNT_W-1:0] cnt_d [INPUT_SIZE];

        // Per-pin counter: clear while agreeing, count while differing, accept on the last count.
        always_comb begin
            stable_d = stable_q;
            for (int i = 0; i < INPUT_SIZE; i++) begin
                cnt_d[i] = cnt_q[i];
                if (sync[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] < CNT_LAST) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end else begin
                    stable_d[i] = sync[i];
                    cnt_d[i]    = '0;
                end
            end
        end

        // Debounce counters; reset abandons any count in progress.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < INPUT_SIZE; i++) begin
                    cnt_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < INPUT_SIZE; i++) begin
                    cnt_q[i] <= cnt_d[i];
                end
            end
        end
    end

    // Accepted (debounced) input values.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= '0;
        end else begin
            stable_q <= stable_d;
        end
    end

    // Flat read map over the whole address space so the address indexes it directly.
    always_comb begin
        rd_map                          = '0;
        rd_map[OUTPUT_SIZE-1:0]         = latch_q;
        rd_map[MAPPED-1:OUTPUT_SIZE]    = stable_q;
    end

    assign data_out    = rd_map[address];
    assign addr_err    = addr_err_q;
    assign output_pins = latch_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Testbench for io_port_bank with 4 address bits, 4 outputs, 4 inputs,
// 2 sync stages, 3-cycle debounce and output reset value 4'b1010.
module tb_io_port_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       write;
    logic       data_in;
    logic [3:0] address;
    logic       data_out;
    logic       addr_err;
    logic [3:0] input_pins;
    logic [3:0] output_pins;

    int checks = 0;
    int errors = 0;

    logic [3:0] model_lat;
    logic [3:0] exp_q[$];
    logic [3:0] exp_v;
    logic [3:0] got;

    always #5 clk = ~clk;

    io_port_bank #(
        .ADDR_WIDTH     (4),
        .OUTPUT_SIZE    (4),
        .INPUT_SIZE     (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(3),
        .OUTPUT_RESET   (4'b1010)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .write      (write),
        .data_in    (data_in),
        .address    (address),
        .data_out   (data_out),
        .addr_err   (addr_err),
        .input_pins (input_pins),
        .output_pins(output_pins)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; write = 1'b0; data_in = 1'b0; address = 4'd4; input_pins = 4'b0000;
        step();
        rst = 1'b0;
        model_lat = 4'b1010;
        exp_q.push_back(4'b1010);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (output_pins !== exp_v) begin
            errors++; $display("FAIL reset_output_pins: got %b required %b", output_pins, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (addr_err !== exp_v[0]) begin
            errors++; $display("FAIL reset_addr_err: got %b required %b", addr_err, exp_v[0]);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (data_out !== exp_v[0]) begin
            errors++; $display("FAIL reset_data_out_a4: got %b required %b", data_out, exp_v[0]);
        end
        for (int a = 0; a < 4; a++) begin
            address = 4'(a);
            exp_q.push_back({3'b000, model_lat[a]});
            #1;
            exp_v = exp_q.pop_front(); checks++;
            if (data_out !== exp_v[0]) begin
                errors++; $display("FAIL reset_readback a=%0d: got %b required %b", a, data_out, exp_v[0]);
            end
        end
    endtask

    task automatic test_write();
        step();
        address = 4'd2; write = 1'b1; data_in = 1'b1;
        exp_q.push_back(4'b0000);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (data_out !== exp_v[0]) begin
            errors++; $display("FAIL write_old_readback: got %b required %b", data_out, exp_v[0]);
        end
        step();
        write = 1'b0;
        model_lat[2] = 1'b1;
        exp_q.push_back(4'b1110);
        exp_q.push_back(4'b0001);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (output_pins !== exp_v) begin
            errors++; $display("FAIL write_output_pins: got %b required %b", output_pins, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (data_out !== exp_v[0]) begin
            errors++; $display("FAIL write_new_readback: got %b required %b", data_out, exp_v[0]);
        end
    endtask

    task automatic test_back_to_back();
        step();
        for (int n = 0; n < 12; n++) begin
            address = 4'($urandom_range(0, 3));
            data_in = 1'($urandom);
            write   = 1'b1;
            exp_q.push_back(model_lat);
            exp_q.push_back({3'b000, model_lat[address]});
            @(negedge clk);
            exp_v = exp_q.pop_front(); checks++;
            if (output_pins !== exp_v) begin
                errors++; $display("FAIL b2b_output_pins n=%0d: got %b required %b", n, output_pins, exp_v);
            end
            exp_v = exp_q.pop_front(); checks++;
            if (data_out !== exp_v[0]) begin
                errors++; $display("FAIL b2b_readback n=%0d: got %b required %b", n, data_out, exp_v[0]);
            end
            model_lat[address] = data_in;
            step();
        end
        write = 1'b0;
        exp_q.push_back(model_lat);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (output_pins !== exp_v) begin
            errors++; $display("FAIL b2b_final_pins: got %b required %b", output_pins, exp_v);
        end
    endtask

    task automatic test_unmapped();
        step();
        address = 4'd12; write = 1'b1; data_in = 1'b1;
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (data_out !== exp_v[0]) begin
            errors++; $display("FAIL unmapped_data_out: got %b required %b", data_out, exp_v[0]);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (addr_err !== exp_v[0]) begin
            errors++; $display("FAIL unmapped_err_before: got %b required %b", addr_err, exp_v[0]);
        end
        step();
        write = 1'b0; address = 4'd0;
        exp_q.push_back(4'b0001);
        exp_q.push_back(model_lat);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (addr_err !== exp_v[0]) begin
            errors++; $display("FAIL unmapped_err_set: got %b required %b", addr_err, exp_v[0]);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (output_pins !== exp_v) begin
            errors++; $display("FAIL unmapped_pins_kept: got %b required %b", output_pins, exp_v);
        end
        step();
        exp_q.push_back(4'b0000);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (addr_err !== exp_v[0]) begin
            errors++; $display("FAIL unmapped_err_clear: got %b required %b", addr_err, exp_v[0]);
        end
        // write to an input address is ignored, then first unmapped address 8
        address = 4'd5; write = 1'b1; data_in = ~model_lat[1];
        step();
        write = 1'b0; address = 4'd8;
        exp_q.push_back(model_lat);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0000);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (output_pins !== exp_v) begin
            errors++; $display("FAIL input_addr_write_ignored: got %b required %b", output_pins, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (addr_err !== exp_v[0]) begin
            errors++; $display("FAIL input_addr_no_err: got %b required %b", addr_err, exp_v[0]);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (data_out !== exp_v[0]) begin
            errors++; $display("FAIL addr8_data_out: got %b required %b", data_out, exp_v[0]);
        end
        step();
        address = 4'd0;
        exp_q.push_back(4'b0001);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (addr_err !== exp_v[0]) begin
            errors++; $display("FAIL addr8_err_set: got %b required %b", addr_err, exp_v[0]);
        end
    endtask

    task automatic test_debounce_latency();
        step();
        address = 4'd5; input_pins = 4'b0010;
        for (int k = 0; k <= 5; k++) exp_q.push_back({3'b000, (k == 5)});
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (data_out !== exp_v[0]) begin
            errors++; $display("FAIL latency edge 0: got %b required %b", data_out, exp_v[0]);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            @(negedge clk);
            exp_v = exp_q.pop_front(); checks++;
            if (data_out !== exp_v[0]) begin
                errors++; $display("FAIL latency edge %0d: got %b required %b", k, data_out, exp_v[0]);
            end
        end
    endtask

    task automatic test_glitch();
        step();
        address = 4'd4; input_pins[0] = 1'b1;
        step();
        step();
        input_pins[0] = 1'b0;
        for (int k = 0; k < 8; k++) exp_q.push_back(4'b0000);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front(); checks++;
            if (data_out !== exp_v[0]) begin
                errors++; $display("FAIL glitch_stays_low k=%0d: got %b required %b", k, data_out, exp_v[0]);
            end
            step();
        end
        // counter must have returned to 0: a held change takes the full 5 edges
        input_pins[0] = 1'b1;
        for (int k = 1; k <= 5; k++) exp_q.push_back({3'b000, (k == 5)});
        for (int k = 1; k <= 5; k++) begin
            step();
            @(negedge clk);
            exp_v = exp_q.pop_front(); checks++;
            if (data_out !== exp_v[0]) begin
                errors++; $display("FAIL glitch_relatch edge %0d: got %b required %b", k, data_out, exp_v[0]);
            end
        end
    endtask

    task automatic test_rst_priority();
        step();
        rst = 1'b1; write = 1'b1; address = 4'd1; data_in = 1'b0;
        step();
        rst = 1'b0; write = 1'b0;
        model_lat = 4'b1010;
        exp_q.push_back(4'b1010);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (output_pins !== exp_v) begin
            errors++; $display("FAIL rst_priority_pins: got %b required %b", output_pins, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (data_out !== exp_v[0]) begin
            errors++; $display("FAIL rst_priority_readback: got %b required %b", data_out, exp_v[0]);
        end
        address = 4'd5;
        #1;
        exp_v = exp_q.pop_front(); checks++;
        if (data_out !== exp_v[0]) begin
            errors++; $display("FAIL rst_clears_stable: got %b required %b", data_out, exp_v[0]);
        end
    endtask

    task automatic test_reset_midcount();
        step();
        input_pins = 4'b0000; rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) step();
        address = 4'd5; input_pins = 4'b0010;
        for (int k = 1; k <= 3; k++) exp_q.push_back(4'b0000);
        for (int k = 1; k <= 3; k++) begin
            step();
            @(negedge clk);
            exp_v = exp_q.pop_front(); checks++;
            if (data_out !== exp_v[0]) begin
                errors++; $display("FAIL midcount_pre edge %0d: got %b required %b", k, data_out, exp_v[0]);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b1010);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (data_out !== exp_v[0]) begin
            errors++; $display("FAIL midcount_after_rst: got %b required %b", data_out, exp_v[0]);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (output_pins !== exp_v) begin
            errors++; $display("FAIL midcount_rst_pins: got %b required %b", output_pins, exp_v);
        end
        for (int k = 1; k <= 5; k++) exp_q.push_back({3'b000, (k == 5)});
        for (int k = 1; k <= 5; k++) begin
            step();
            @(negedge clk);
            exp_v = exp_q.pop_front(); checks++;
            if (data_out !== exp_v[0]) begin
                errors++; $display("FAIL midcount_restart edge %0d: got %b required %b", k, data_out, exp_v[0]);
            end
        end
    endtask

    task automatic test_multi_channel();
        step();
        input_pins = 4'b0000; rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) step();
        // pin2 rises first, pin0 and pin3 rise together later, pin1 only glitches
        for (int k = 1; k <= 10; k++) begin
            exp_v = 4'b0000;
            exp_v[2] = (k >= 5);
            exp_v[0] = (k >= 7);
            exp_v[3] = (k >= 7);
            exp_q.push_back(exp_v);
        end
        for (int k = 1; k <= 10; k++) begin
            if (k == 1) input_pins[2] = 1'b1;
            if (k == 2) input_pins[1] = 1'b1;
            if (k == 3) begin input_pins[0] = 1'b1; input_pins[3] = 1'b1; end
            if (k == 4) input_pins[1] = 1'b0;
            step();
            @(negedge clk);
            got = 4'b0000;
            for (int a = 0; a < 4; a++) begin
                address = 4'(4 + a);
                #1;
                got[a] = data_out;
            end
            exp_v = exp_q.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL multi_channel edge %0d: got %b required %b", k, got, exp_v);
            end
        end
        address = 4'd0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_unmapped();
        test_debounce_latency();
        test_glitch();
        test_rst_priority();
        test_reset_midcount();
        test_multi_channel();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
